// File: rtl/brick_mac_sequencer.sv
// brick_mac_sequencer
//
// Drives a single 2b x 2b reconfigurable bit-brick multiplier to compute a
// precision-scalable dot product. Each accepted operand pair is decomposed into
// 2-bit activation/weight slices. One slice combination is issued per cycle, and
// the brick's combinational product is shift-accumulated into the running sum.
// The sum is presented when the pair flagged last has finished.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   in_valid/in_ready   operand pair handshake
//   in_act, in_wgt      8-bit operands, sliced [1:0],[3:2],[5:4],[7:6]
//   in_prec_a/_w        0=2b, 1=4b, 2/3=8b
//   in_signed_a/_w      operand is two's complement
//   in_last             pair closes the dot product
//   brick_a, brick_b    slices driven to the brick
//   brick_sign_i/_w     brick sign controls (set on the top slice only)
//   brick_mul           6-bit signed brick product, same cycle
//   out_valid/out_ready result handshake
//   out_data            accumulated dot product (ACC_W bits, modulo 2^ACC_W)
//   busy                sequencer not idle
module brick_mac_sequencer #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_act,
    input  logic [7:0]       in_wgt,
    input  logic [1:0]       in_prec_a,
    input  logic [1:0]       in_prec_w,
    input  logic             in_signed_a,
    input  logic             in_signed_w,
    input  logic             in_last,
    output logic [1:0]       brick_a,
    output logic [1:0]       brick_b,
    output logic             brick_sign_i,
    output logic             brick_sign_w,
    input  logic [5:0]       brick_mul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_reg, state_next;
    logic [7:0]        act_reg, act_next;
    logic [7:0]        wgt_reg, wgt_next;
    // Index of the top slice (n-1) rather than the slice count itself.
    logic [1:0]        top_a_reg, top_a_next;
    logic [1:0]        top_w_reg, top_w_next;
    logic [1:0]        i_reg, i_next;
    logic [1:0]        j_reg, j_next;
    logic              sa_reg, sa_next;
    logic              sw_reg, sw_next;
    logic              last_reg, last_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;

    logic [ACC_W-1:0]  prod_ext;
    logic [2:0]        slice_sum;
    logic [3:0]        shamt;

    function automatic logic [1:0] top_slice(input logic [1:0] prec);
        case (prec)
            2'd0:    top_slice = 2'd0;
            2'd1:    top_slice = 2'd1;
            default: top_slice = 2'd3;
        endcase
    endfunction

    // Brick product weighted by 4^(i+j): shift by 2*(i+j) bits.
    assign prod_ext  = {{(ACC_W-6){brick_mul[5]}}, brick_mul};
    assign slice_sum = {1'b0, i_reg} + {1'b0, j_reg};
    assign shamt     = {slice_sum, 1'b0};

    always_comb begin
        state_next   = state_reg;
        act_next     = act_reg;
        wgt_next     = wgt_reg;
        top_a_next   = top_a_reg;
        top_w_next   = top_w_reg;
        i_next       = i_reg;
        j_next       = j_reg;
        sa_next      = sa_reg;
        sw_next      = sw_reg;
        last_next    = last_reg;
        acc_next     = acc_reg;
        in_ready     = 1'b0;
        brick_a      = 2'b00;
        brick_b      = 2'b00;
        brick_sign_i = 1'b0;
        brick_sign_w = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;

        case (state_reg)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) begin
                    act_next   = in_act;
                    wgt_next   = in_wgt;
                    top_a_next = top_slice(in_prec_a);
                    top_w_next = top_slice(in_prec_w);
                    sa_next    = in_signed_a;
                    sw_next    = in_signed_w;
                    last_next  = in_last;
                    i_next     = 2'd0;
                    j_next     = 2'd0;
                    state_next = RUN;
                end
            end

            RUN: begin
                brick_a      = act_reg[{i_reg, 1'b0} +: 2];
                brick_b      = wgt_reg[{j_reg, 1'b0} +: 2];
                brick_sign_i = sa_reg & (i_reg == top_a_reg);
                brick_sign_w = sw_reg & (j_reg == top_w_reg);
                acc_next     = acc_reg + (prod_ext << shamt);
                if (i_reg == top_a_reg) begin
                    i_next = 2'd0;
                    if (j_reg == top_w_reg) begin
                        j_next     = 2'd0;
                        state_next = last_reg ? DONE : IDLE;
                    end else begin
                        j_next = j_reg + 2'd1;
                    end
                end else begin
                    i_next = i_reg + 2'd1;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                out_data  = acc_reg;
                if (out_ready) begin
                    acc_next   = '0;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            act_reg   <= 8'd0;
            wgt_reg   <= 8'd0;
            top_a_reg <= 2'd0;
            top_w_reg <= 2'd0;
            i_reg     <= 2'd0;
            j_reg     <= 2'd0;
            sa_reg    <= 1'b0;
            sw_reg    <= 1'b0;
            last_reg  <= 1'b0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            act_reg   <= act_next;
            wgt_reg   <= wgt_next;
            top_a_reg <= top_a_next;
            top_w_reg <= top_w_next;
            i_reg     <= i_next;
            j_reg     <= j_next;
            sa_reg    <= sa_next;
            sw_reg    <= sw_next;
            last_reg  <= last_next;
            acc_reg   <= acc_next;
        end
    end

endmodule

// File: tb/tb_brick_mac_sequencer.sv
// Directed testbench for brick_mac_sequencer. It includes a behavioural model of
// the 2b x 2b bit-brick: each 2-bit slice is sign-extended when its sign control
// is set, and the product is returned as 6-bit two's complement.
module tb_brick_mac_sequencer;

    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_act;
    logic [7:0]       in_wgt;
    logic [1:0]       in_prec_a;
    logic [1:0]       in_prec_w;
    logic             in_signed_a;
    logic             in_signed_w;
    logic             in_last;
    logic [1:0]       brick_a;
    logic [1:0]       brick_b;
    logic             brick_sign_i;
    logic             brick_sign_w;
    logic [5:0]       brick_mul;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             busy;

    int tests = 0;
    int fails = 0;

    brick_mac_sequencer #(.ACC_W(ACC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_act       (in_act),
        .in_wgt       (in_wgt),
        .in_prec_a    (in_prec_a),
        .in_prec_w    (in_prec_w),
        .in_signed_a  (in_signed_a),
        .in_signed_w  (in_signed_w),
        .in_last      (in_last),
        .brick_a      (brick_a),
        .brick_b      (brick_b),
        .brick_sign_i (brick_sign_i),
        .brick_sign_w (brick_sign_w),
        .brick_mul    (brick_mul),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Brick model
    logic signed [3:0] bm_a, bm_b;
    logic signed [7:0] bm_p;
    always_comb begin
        bm_a      = brick_sign_i ? {{2{brick_a[1]}}, brick_a} : {2'b00, brick_a};
        bm_b      = brick_sign_w ? {{2{brick_b[1]}}, brick_b} : {2'b00, brick_b};
        bm_p      = bm_a * bm_b;
        brick_mul = bm_p[5:0];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one pair, waits for acceptance, then counts RUN cycles until the
    // sequencer is idle again or shows a result. Sign controls are recorded per
    // RUN cycle so that their pattern can be checked.
    task automatic send(input string tag, input logic [7:0] a, input logic [7:0] w,
                        input logic [1:0] pa, input logic [1:0] pw,
                        input logic sa, input logic sw, input logic last,
                        output int runs, output logic [15:0] si_mask,
                        output logic [15:0] sw_mask);
        int k;
        in_act      = a;
        in_wgt      = w;
        in_prec_a   = pa;
        in_prec_w   = pw;
        in_signed_a = sa;
        in_signed_w = sw;
        in_last     = last;
        in_valid    = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        runs     = 0;
        si_mask  = '0;
        sw_mask  = '0;
        while (!(in_ready || out_valid) && runs < 100) begin
            if (runs < 16) begin
                si_mask[runs] = brick_sign_i;
                sw_mask[runs] = brick_sign_w;
            end
            tick();
            runs++;
        end
        $display("[TB] %s: act=0x%02h wgt=0x%02h prec=%0d/%0d signed=%0d/%0d last=%0d run_cycles=%0d",
                 tag, a, w, pa, pw, sa, sw, last, runs);
    endtask

    task automatic recv(input string tag, input logic [ACC_W-1:0] exp);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_data"}, {{(32-ACC_W){1'b0}}, out_data}, {{(32-ACC_W){1'b0}}, exp});
        $display("[TB] %s: result out_data=0x%06h expected=0x%06h", tag, out_data, exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    int          runs;
    logic [15:0] sim, swm;

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_act      = 8'd0;
        in_wgt      = 8'd0;
        in_prec_a   = 2'd0;
        in_prec_w   = 2'd0;
        in_signed_a = 1'b0;
        in_signed_w = 1'b0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {8'd0, out_data}, 32'd0);
        chk("rst_brick", {26'd0, brick_a, brick_b, brick_sign_i, brick_sign_w}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Unsigned 8b x 8b: 255*255
        send("u8x8", 8'hFF, 8'hFF, 2'd2, 2'd3, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        chk("u8x8_runs", runs, 32'd16);
        chk("u8x8_signs", {sim, swm}, 32'd0);
        recv("u8x8", 24'h00FE01);

        // Signed 4b x 4b: -1 * 7
        send("s4x4", 8'h0F, 8'h07, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, runs, sim, swm);
        chk("s4x4_runs", runs, 32'd4);
        chk("s4x4_sign_i", {28'd0, sim[3:0]}, 32'h0000000A);
        chk("s4x4_sign_w", {28'd0, swm[3:0]}, 32'h0000000C);
        recv("s4x4", 24'hFFFFF9);

        // Signed 2b x 2b: -2 * -2
        send("s2x2", 8'h02, 8'h02, 2'd0, 2'd0, 1'b1, 1'b1, 1'b1, runs, sim, swm);
        chk("s2x2_runs", runs, 32'd1);
        chk("s2x2_signs", {30'd0, sim[0], swm[0]}, 32'd3);
        recv("s2x2", 24'd4);

        // Unused upper operand bits ignored: 2b slices 01 x 10
        send("upper", 8'hAD, 8'h32, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        recv("upper", 24'd2);

        // Mixed dot product: 200*3 + (-8)*5 + 3*3 = 569
        send("mix1", 8'd200, 8'd3, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0, runs, sim, swm);
        chk("mix1_runs", runs, 32'd16);
        chk("mix1_no_valid", {31'd0, out_valid}, 32'd0);
        send("mix2", 8'h08, 8'h05, 2'd1, 2'd1, 1'b1, 1'b1, 1'b0, runs, sim, swm);
        chk("mix2_runs", runs, 32'd4);
        chk("mix2_no_valid", {31'd0, out_valid}, 32'd0);
        send("mix3", 8'h03, 8'h03, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        chk("mix3_runs", runs, 32'd1);
        recv("mix3", 24'd569);

        // Backpressure: 1*2 held in DONE while the next pair waits
        send("bp", 8'h01, 8'h02, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        in_act    = 8'h02;
        in_wgt    = 8'h03;
        in_prec_a = 2'd0;
        in_prec_w = 2'd0;
        in_signed_a = 1'b0;
        in_signed_w = 1'b0;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int s = 0; s < 5; s++) begin
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_data", {8'd0, out_data}, 32'd2);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        recv("bp", 24'd2);
        send("bp_next", 8'h02, 8'h03, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        chk("bp_next_runs", runs, 32'd1);
        recv("bp_next", 24'd6);

        // Reset on the 4th RUN cycle of an 8b x 8b pair
        in_act      = 8'hFF;
        in_wgt      = 8'hFF;
        in_prec_a   = 2'd2;
        in_prec_w   = 2'd2;
        in_signed_a = 1'b0;
        in_signed_w = 1'b0;
        in_last     = 1'b1;
        in_valid    = 1'b1;
        chk("mr_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("mr_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mr_out_data", {8'd0, out_data}, 32'd0);
        chk("mr_brick", {26'd0, brick_a, brick_b, brick_sign_i, brick_sign_w}, 32'd0);
        rst_n = 1'b1;
        #1;
        send("mr_after", 8'h01, 8'h01, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, runs, sim, swm);
        recv("mr_after", 24'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/brick_mac_sequencer.md
# brick_mac_sequencer

Sequencer that drives one 2b×2b reconfigurable bit-brick multiplier, which has a combinational 6-bit result and separate activation/weight sign controls, to compute a precision-scalable dot product.
- Per accepted operand pair, walks all 2-bit activation × weight slice combinations, one per cycle.
- Sets the per-slice sign controls, then shift-accumulates the brick products.
- Presents the accumulated sum when the pair flagged last completes.
- Sits between the operand feeder and the output writeback in a BitBlade processing element.

## Interface
Parameters:
- ACC_W, 24, accumulator/result width; ≥16.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept a pair.
- in_act  in  8  activation; slices [1:0],[3:2],[5:4],[7:6].
- in_wgt  in  8  weight; same slicing.
- in_prec_a  in  2  activation precision: 0=2b, 1=4b, 2/3=8b.
- in_prec_w  in  2  weight precision, same encoding.
- in_signed_a  in  1  activation is two's complement.
- in_signed_w  in  1  weight is two's complement.
- in_last  in  1  pair closes the dot product.
- brick_a  out  2  activation slice to brick.
- brick_b  out  2  weight slice to brick.
- brick_sign_i  out  1  brick activation sign control.
- brick_sign_w  out  1  brick weight sign control.
- brick_mul  in  6  brick product, two's complement, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.
- out_data  out  ACC_W  dot-product result.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch act, wgt, precisions, sign flags and last.
  - Set n_a = 1/2/4 slices from prec_a, n_w likewise.
  - Clear slice counters i (activation) and j (weight); go to RUN.
- RUN, one brick product per cycle:
  - brick_a = act[2i+1:2i]; brick_b = wgt[2j+1:2j].
  - brick_sign_i = signed_a & (i==n_a-1); brick_sign_w = signed_w & (j==n_w-1).
  - acc += sign_extend(brick_mul, ACC_W) << 2(i+j).
  - i increments fastest; on i==n_a-1, i←0 and j++.
  - After cycle (n_a-1, n_w-1): go to DONE if latched last, else IDLE.
- DONE:
  - out_valid=1; out_data=acc, held stable.
  - On out_ready: acc←0, go to IDLE.
- Arithmetic:
  - Accumulation is modulo 2^ACC_W; no saturation, no overflow flag.
  - Unused upper operand bits are ignored.
- Precision and signedness may differ between pairs of one dot product; each pair uses its own latched config.
- Brick outputs (brick_a, brick_b, sign controls) are 0 outside RUN.
- in_ready=0 in RUN and DONE; inputs are ignored there.
- in_ready is 0 while rst_n is low.

## Timing
- Reset (rst_n low at a rising edge):
  - state=IDLE, acc=0, counters=0.
  - out_valid=0, out_data=0, busy=0, brick_* = 0.
  - Applies mid-RUN or mid-DONE too; the partial sum is discarded and a pending result is dropped.
- Accept at edge T → RUN cycles T+1 … T+n_a·n_w.
- Pair throughput: 1 + n_a·n_w cycles (2 for 2b×2b, 17 for 8b×8b).
- Last pair: out_valid first high in cycle T+n_a·n_w+1; stays high until out_ready is sampled high.
- out_valid and out_ready both high at an edge → transfer; next cycle is IDLE with in_ready=1.
- out_ready high in cycle one of DONE → out_valid lasts exactly one cycle.
- brick_mul is sampled in the same cycle its slices are driven; no brick pipeline stage.
- acc wrap at 2^ACC_W is silent.

## Test plan
- Unsigned 8b×8b:
  - Stimulus: act=0xFF, wgt=0xFF, signed=0/0, last=1.
  - Response: 16 RUN cycles; out_data=0x00FE01; out_valid 17 cycles after accept.
- Signed 4b×4b:
  - Stimulus: act=0xF (-1), wgt=0x7, signed_a=1, signed_w=1, last=1.
  - Response: out_data=0xFFFFF9 (-7); brick_sign_i high only when i=1.
- Signed 2b×2b:
  - Stimulus: act=2'b10, wgt=2'b10, signed=1/1.
  - Response: one RUN cycle with both sign controls high; out_data=4.
- Mixed dot product, three pairs, last on the third:
  - Pair 1: 8b unsigned 200×3.
  - Pair 2: 4b signed (-8)×5.
  - Pair 3: 2b unsigned 3×3.
  - Response: out_data=569; out_valid only after pair 3.
- Backpressure:
  - Stimulus: out_ready low for 5 cycles in DONE; in_valid held high.
  - Response: out_valid/out_data stable, in_ready=0; pair accepted the cycle after the transfer.
- Reset mid-RUN:
  - Stimulus: rst_n low on the 4th RUN cycle of 8b×8b, then a 2b pair 1×1 with last=1.
  - Response: all outputs reset values; next result=1 (no stale partial sum).
